// File: rtl/pcileech_fake_eth_tx_queue.sv
// Transmit queue behind the fake Ethernet BAR: TX_DATA pushes, TX_CTRL commit/flush, paced wire drain.
// Optional loopback port enabled by PCILEECH_FAKE_ETH_TX_LOOPBACK_EN (tied to zero when undefined).
module pcileech_fake_eth_tx_queue #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DRAIN_DIV  = 4,
   parameter int IFG_CYCLES = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           wr_addr,
   input  logic [3:0]            wr_be,
   input  logic [31:0]           wr_data,
   input  logic                  wr_valid,
   output logic [DEPTH_LOG2:0]   tx_level,
   output logic [7:0]            tx_pending,
   output logic [31:0]           tx_frames,
   output logic                  tx_overflow,
   output logic                  tx_busy,
   output logic                  tx_done,
   output logic [31:0]           lb_data,
   output logic                  lb_last,
   output logic                  lb_valid
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ZERO  = {(DEPTH_LOG2 + 1){1'b0}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DIV_W-1:0]      DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]      DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(DRAIN_DIV - 1);
   localparam logic [GAP_W-1:0]      GAP_ZERO  = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
   localparam logic [31:0]           ADDR_DATA = 32'h0000_0008;
   localparam logic [31:0]           ADDR_CTRL = 32'h0000_000C;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   logic [32:0]           mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   level_r;
   logic [DEPTH_LOG2:0]   uncomm_r;
   logic [7:0]            pending_r;
   logic [31:0]           frames_r;
   logic                  ovf_r;
   state_t                state_r;
   logic [DIV_W-1:0]      div_cnt_r;
   logic [GAP_W-1:0]      gap_cnt_r;
   logic                  done_r;
   logic                  busy_r;

   logic data_wr_s;
   logic ctrl_wr_s;
   logic flush_s;
   logic clr_ovf_s;
   logic commit_ok_s;
   logic pop_s;
   logic last_pop_s;
   logic full_s;
   logic push_s;
   logic drop_s;

   // Write decode and FIFO handshake qualifiers; FLUSH outranks COMMIT and any pop.
   always_comb begin
      data_wr_s   = wr_valid && (wr_addr == ADDR_DATA) && (wr_be == 4'hF);
      ctrl_wr_s   = wr_valid && (wr_addr == ADDR_CTRL) && wr_be[0];
      flush_s     = ctrl_wr_s && wr_data[1];
      clr_ovf_s   = ctrl_wr_s && wr_data[2];
      commit_ok_s = ctrl_wr_s && wr_data[0] && !flush_s &&
                    (uncomm_r != LVL_ZERO) && (pending_r != 8'hFF);
      pop_s       = (state_r == ST_DRAIN) && (div_cnt_r == DIV_LAST) &&
                    (level_r != LVL_ZERO) && !flush_s;
      last_pop_s  = pop_s && mem_r[rd_ptr_r][32];
      full_s      = (level_r == LVL_FULL) && !pop_s;
      push_s      = data_wr_s && !full_s;
      drop_s      = data_wr_s && full_s;
   end

   // FIFO storage; a commit marks the most recently pushed entry as end-of-frame.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {1'b0, wr_data};
      end else if (commit_ok_s) begin
         mem_r[wr_ptr_r - PTR_ONE][32] <= 1'b1;
      end
   end

   // Pointers, occupancy, frame bookkeeping and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r  <= PTR_ZERO;
         rd_ptr_r  <= PTR_ZERO;
         level_r   <= LVL_ZERO;
         uncomm_r  <= LVL_ZERO;
         pending_r <= 8'd0;
         frames_r  <= 32'd0;
         ovf_r     <= 1'b0;
      end else begin
         if (flush_s) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            level_r   <= LVL_ZERO;
            uncomm_r  <= LVL_ZERO;
            pending_r <= 8'd0;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_r + {{DEPTH_LOG2{1'b0}}, push_s} - {{DEPTH_LOG2{1'b0}}, pop_s};
            if (commit_ok_s) begin
               uncomm_r <= LVL_ZERO;
            end else if (push_s) begin
               uncomm_r <= uncomm_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
            pending_r <= pending_r + {7'd0, commit_ok_s} - {7'd0, last_pop_s};
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf_s) begin
            ovf_r <= 1'b0;
         end
         if (last_pop_s) begin
            frames_r <= frames_r + 32'd1;
         end
      end
   end

   // Wire emulation FSM: paced drain of committed frames followed by the inter-frame gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         div_cnt_r <= DIV_ZERO;
         gap_cnt_r <= GAP_ZERO;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else if (flush_s) begin
         state_r   <= ST_IDLE;
         div_cnt_r <= DIV_ZERO;
         gap_cnt_r <= GAP_ZERO;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         done_r <= last_pop_s;
         case (state_r)
            ST_IDLE: begin
               // Reacting to the commit strobe directly puts DRAIN one clock after the write.
               if ((pending_r != 8'd0) || commit_ok_s) begin
                  state_r   <= ST_DRAIN;
                  div_cnt_r <= DIV_ZERO;
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            ST_DRAIN: begin
               busy_r <= 1'b1;
               if (div_cnt_r == DIV_LAST) begin
                  div_cnt_r <= DIV_ZERO;
                  if (last_pop_s) begin
                     state_r   <= ST_GAP;
                     gap_cnt_r <= GAP_ZERO;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_ONE;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_ONE;
                  busy_r    <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               div_cnt_r <= DIV_ZERO;
               gap_cnt_r <= GAP_ZERO;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PCILEECH_FAKE_ETH_TX_LOOPBACK_EN
   logic [31:0] lb_data_r;
   logic        lb_last_r;
   logic        lb_valid_r;

   // Loopback copy of each drained word, presented one clock after its pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lb_data_r  <= 32'd0;
         lb_last_r  <= 1'b0;
         lb_valid_r <= 1'b0;
      end else begin
         lb_valid_r <= pop_s;
         if (pop_s) begin
            lb_data_r <= mem_r[rd_ptr_r][31:0];
            lb_last_r <= mem_r[rd_ptr_r][32];
         end
      end
   end

   assign lb_data  = lb_data_r;
   assign lb_last  = lb_last_r;
   assign lb_valid = lb_valid_r;
`else
   assign lb_data  = 32'd0;
   assign lb_last  = 1'b0;
   assign lb_valid = 1'b0;
`endif

   assign tx_level    = level_r;
   assign tx_pending  = pending_r;
   assign tx_frames   = frames_r;
   assign tx_overflow = ovf_r;
   assign tx_busy     = busy_r;
   assign tx_done     = done_r;

endmodule

// File: tb/tb_pcileech_fake_eth_tx_queue.sv
// Directed bench for pcileech_fake_eth_tx_queue (default build, loopback disabled).
module tb_pcileech_fake_eth_tx_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wr_addr = 32'd0;
   logic [3:0]  wr_be = 4'd0;
   logic [31:0] wr_data = 32'd0;
   logic        wr_valid = 1'b0;
   logic [4:0]  tx_level;
   logic [7:0]  tx_pending;
   logic [31:0] tx_frames;
   logic        tx_overflow;
   logic        tx_busy;
   logic        tx_done;
   logic [31:0] lb_data;
   logic        lb_last;
   logic        lb_valid;

   int errors = 0;
   int checks = 0;
   int lb_seen = 0;

   pcileech_fake_eth_tx_queue #(.DEPTH_LOG2(4), .DRAIN_DIV(4), .IFG_CYCLES(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
      .tx_level(tx_level), .tx_pending(tx_pending), .tx_frames(tx_frames),
      .tx_overflow(tx_overflow), .tx_busy(tx_busy), .tx_done(tx_done),
      .lb_data(lb_data), .lb_last(lb_last), .lb_valid(lb_valid)
   );

   always #5 clk = ~clk;

   // Loopback must stay silent in the default build.
   always @(negedge clk) begin
      if (lb_valid || lb_last || (lb_data != 32'd0)) lb_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      @(posedge clk); #1;
      wr_addr = a; wr_be = be; wr_data = d; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300 && tx_busy; i++) tick(1);
      chk(tag, {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      int done_at;
      int done_cnt;
      int d1;
      int d2;

      // Reset state
      tick(3);
      chk("rst_level", {27'd0, tx_level}, 32'd0);
      chk("rst_pending", {24'd0, tx_pending}, 32'd0);
      chk("rst_frames", tx_frames, 32'd0);
      chk("rst_busy_ovf_done", {29'd0, tx_overflow, tx_busy, tx_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // 1: three-word frame
      wr(32'h8, 4'hF, 32'h11);
      wr(32'h8, 4'hF, 32'h22);
      wr(32'h8, 4'hF, 32'h33);
      chk("t1_level_pushed", {27'd0, tx_level}, 32'd3);
      wr(32'hC, 4'hF, 32'h1);
      chk("t1_pending", {24'd0, tx_pending}, 32'd1);
      chk("t1_busy", {31'd0, tx_busy}, 32'd1);
      done_at = 0; done_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (k == 3)  chk("t1_level_k3", {27'd0, tx_level}, 32'd3);
         if (k == 4)  chk("t1_level_k4", {27'd0, tx_level}, 32'd2);
         if (k == 8)  chk("t1_level_k8", {27'd0, tx_level}, 32'd1);
         if (k == 12) chk("t1_level_k12", {27'd0, tx_level}, 32'd0);
         if (tx_done) begin done_at = k; done_cnt++; end
      end
      chk("t1_done_at", done_at, 32'd12);
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_frames", tx_frames, 32'd1);
      chk("t1_pending_end", {24'd0, tx_pending}, 32'd0);
      tick(11);
      chk("t1_gap_busy", {31'd0, tx_busy}, 32'd1);
      tick(1);
      chk("t1_idle", {31'd0, tx_busy}, 32'd0);

      // 2: overflow with 17 uncommitted pushes
      for (int i = 0; i < 17; i++) wr(32'h8, 4'hF, 32'h100 + i);
      chk("t2_level_full", {27'd0, tx_level}, 32'd16);
      chk("t2_ovf", {31'd0, tx_overflow}, 32'd1);
      tick(10);
      chk("t2_no_drain", {27'd0, tx_level}, 32'd16);
      chk("t2_not_busy", {31'd0, tx_busy}, 32'd0);
      wr(32'hC, 4'hF, 32'h4);
      chk("t2_clr_ovf", {31'd0, tx_overflow}, 32'd0);
      wr(32'hC, 4'hF, 32'h1);
      done_at = 0;
      for (int k = 1; k <= 80; k++) begin
         tick(1);
         if (tx_done && done_at == 0) done_at = k;
      end
      chk("t2_done_at", done_at, 32'd64);
      chk("t2_frames", tx_frames, 32'd2);
      chk("t2_level_end", {27'd0, tx_level}, 32'd0);
      wait_idle("t2_idle_timeout");

      // 3: two frames back-to-back
      wr(32'h8, 4'hF, 32'hA0);
      wr(32'h8, 4'hF, 32'hA1);
      wr(32'hC, 4'hF, 32'h1);
      wr(32'h8, 4'hF, 32'hB0);
      wr(32'h8, 4'hF, 32'hB1);
      wr(32'hC, 4'hF, 32'h1);
      chk("t3_pending_peak", {24'd0, tx_pending}, 32'd2);
      d1 = 0; d2 = 0; done_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         tick(1);
         if (tx_done) begin
            done_cnt++;
            if (d1 == 0) d1 = k; else if (d2 == 0) d2 = k;
         end
      end
      chk("t3_first_done", d1, 32'd2);
      chk("t3_done_spacing", d2 - d1, 32'd21);
      chk("t3_done_cnt", done_cnt, 32'd2);
      chk("t3_frames", tx_frames, 32'd4);
      wait_idle("t3_idle_timeout");

      // 4: ignored writes
      wr(32'hC, 4'hF, 32'h1);
      chk("t4_empty_commit", {24'd0, tx_pending}, 32'd0);
      tick(1);
      chk("t4_empty_busy", {31'd0, tx_busy}, 32'd0);
      wr(32'h8, 4'h3, 32'hDEAD);
      chk("t4_partial_be", {27'd0, tx_level}, 32'd0);
      wr(32'h8, 4'hF, 32'h44);
      wr(32'hC, 4'hE, 32'h1);
      chk("t4_ctrl_be0", {24'd0, tx_pending}, 32'd0);
      wr(32'h10, 4'hF, 32'h1);
      chk("t4_bad_addr", {27'd0, tx_level}, 32'd1);
      wr(32'hC, 4'hF, 32'h2);
      chk("t4_idle_flush", {27'd0, tx_level}, 32'd0);

      // 5: flush mid-drain
      for (int i = 0; i < 8; i++) wr(32'h8, 4'hF, 32'h500 + i);
      wr(32'hC, 4'hF, 32'h1);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_level_before", {27'd0, tx_level}, 32'd6);
      wr(32'hC, 4'hF, 32'h2);
      chk("t5_level", {27'd0, tx_level}, 32'd0);
      chk("t5_busy", {31'd0, tx_busy}, 32'd0);
      chk("t5_pending", {24'd0, tx_pending}, 32'd0);
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick(1);
         if (tx_done) done_cnt++;
      end
      chk("t5_no_done", done_cnt, 32'd0);
      chk("t5_frames", tx_frames, 32'd4);

      // 6: async reset mid-drain with tx_frames=5
      wr(32'h8, 4'hF, 32'h600);
      wr(32'hC, 4'hF, 32'h1);
      wait_idle("t6_idle_timeout");
      chk("t6_frames5", tx_frames, 32'd5);
      for (int i = 0; i < 4; i++) wr(32'h8, 4'hF, 32'h700 + i);
      wr(32'hC, 4'hF, 32'h1);
      tick(3);
      chk("t6_mid_busy", {31'd0, tx_busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_frames", tx_frames, 32'd0);
      chk("t6_async_level", {27'd0, tx_level}, 32'd0);
      chk("t6_async_flags", {21'd0, tx_pending, tx_overflow, tx_busy, tx_done}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(1);
      chk("t6_post_busy", {31'd0, tx_busy}, 32'd0);
      chk("t6_post_frames", tx_frames, 32'd0);
      wr(32'h8, 4'hF, 32'h800);
      wr(32'hC, 4'hF, 32'h1);
      tick(4);
      chk("t6_new_done", {31'd0, tx_done}, 32'd1);
      chk("t6_new_frames", tx_frames, 32'd1);

      chk("lb_tied_off", lb_seen, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
